lsu_mem_access: RTL and testbench

- Executes the data-memory access selected by the load/store strobes from the funct3 decoder.
- Drives a req/gnt/rvalid data-memory port, aligns bytes into lanes and generates byte enables.
- Sign- or zero-extends load data.
- Splits misaligned half/word accesses into two word transactions and stalls the core until the access completes.
- Sits between execute/decode control and the data memory.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_mem_access_lane_align.sv | 35 +++
 rtl/lsu_mem_access.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_mem_access.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, byte-enable bases.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE
    } lsu_state_e;

    localparam logic [3:0] BE_BASE_BYTE = 4'b0001;
    localparam logic [3:0] BE_BASE_HALF = 4'b0011;
    localparam logic [3:0] BE_BASE_WORD = 4'b1111;

    function automatic logic [3:0] be_base(input access_size_e size);
        case (size)
            SZ_HALF: return BE_BASE_HALF;
            SZ_WORD: return BE_BASE_WORD;
            default: return BE_BASE_BYTE;
        endcase
    endfunction

    // A halfword at offset 1 stays inside its word, so only offset 3 crosses.
    function automatic logic crosses_word(input access_size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return (off == 2'd3);
            SZ_WORD: return (off != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_access_lane_align.sv
// Byte-lane steering: store data/byte enables across two words, load extract and extend.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]   i_off,
    input  access_size_e i_size,
    input  logic         i_sign,
    input  logic [31:0]  i_wdata,
    input  logic [31:0]  i_word0,
    input  logic [31:0]  i_word1,
    output logic [63:0]  o_st_data,
    output logic [7:0]   o_be,
    output logic [31:0]  o_ld_data
);

    logic [5:0]  w_shamt;
    logic [63:0] w_ld_shift;

    assign w_shamt    = {1'b0, i_off, 3'b000};
    assign o_st_data  = {32'b0, i_wdata} << w_shamt;
    assign o_be       = {4'b0000, be_base(i_size)} << i_off;
    assign w_ld_shift = {i_word1, i_word0} >> w_shamt;

    always_comb begin
        o_ld_data = w_ld_shift[31:0];
        case (i_size)
            SZ_BYTE: o_ld_data = {{24{i_sign & w_ld_shift[7]}},  w_ld_shift[7:0]};
            SZ_HALF: o_ld_data = {{16{i_sign & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: o_ld_data = w_ld_shift[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: drives a req/gnt/rvalid memory port, splits word-crossing accesses in two.
// Latency: 3 cycles IDLE..DONE for an aligned store with immediate gnt; loads add the rvalid delay.
// Backpressure: holds the request stable until mem_gnt and keeps stall high until DONE.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ldr_byte,
    input  logic              ldr_half,
    input  logic              ldr_word,
    input  logic              uldr_byte,
    input  logic              uldr_half,
    input  logic              str_byte,
    input  logic              str_half,
    input  logic              str_word,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              misaligned_err,
    output logic              strobe_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e   r_state;
    access_size_e r_size;
    logic         r_sign;
    logic         r_we;
    logic         r_split;
    logic [1:0]   r_off;
    logic [ADDR_W-1:0] r_addr0;
    logic [31:0]  r_st_hi;
    logic [3:0]   r_be_hi;
    logic [31:0]  r_word0;

    logic [7:0]   w_strb;
    logic         w_any;
    logic         w_multi;
    logic         w_we;
    logic         w_sign;
    logic         w_cross;
    access_size_e w_size;
    logic         w_in_idle;
    logic [1:0]   w_off_a;
    access_size_e w_size_a;
    logic         w_sign_a;
    logic [31:0]  w_word0_a;
    logic [63:0]  w_st_data;
    logic [7:0]   w_be;
    logic [31:0]  w_ld_data;
    logic [ADDR_W-1:0] w_addr_word;

    assign w_strb  = {ldr_byte, ldr_half, ldr_word, uldr_byte, uldr_half, str_byte, str_half, str_word};
    assign w_any   = |w_strb;
    assign w_multi = |(w_strb & (w_strb - 8'd1));
    assign w_we    = str_byte | str_half | str_word;
    assign w_sign  = ldr_byte | ldr_half;
    assign w_cross = crosses_word(w_size, addr[1:0]);
    assign w_addr_word = {addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_size = SZ_BYTE;
        if (ldr_half | uldr_half | str_half) w_size = SZ_HALF;
        if (ldr_word | str_word)             w_size = SZ_WORD;
    end

    // The aligner sees live inputs while a new access is being launched, latched ones afterwards.
    assign w_in_idle = (r_state == IDLE);
    assign w_off_a   = w_in_idle ? addr[1:0] : r_off;
    assign w_size_a  = w_in_idle ? w_size    : r_size;
    assign w_sign_a  = w_in_idle ? w_sign    : r_sign;
    assign w_word0_a = (r_state == WAIT0) ? mem_rdata : r_word0;

    lsu_lane_align u_align (
        .i_off     (w_off_a),
        .i_size    (w_size_a),
        .i_sign    (w_sign_a),
        .i_wdata   (wdata),
        .i_word0   (w_word0_a),
        .i_word1   (mem_rdata),
        .o_st_data (w_st_data),
        .o_be      (w_be),
        .o_ld_data (w_ld_data)
    );

    assign stall = (r_state != IDLE && r_state != DONE) || (r_state == IDLE && w_any);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_size         <= SZ_BYTE;
            r_sign         <= 1'b0;
            r_we           <= 1'b0;
            r_split        <= 1'b0;
            r_off          <= 2'd0;
            r_addr0        <= '0;
            r_st_hi        <= '0;
            r_be_hi        <= '0;
            r_word0        <= '0;
            rdata          <= '0;
            done           <= 1'b0;
            misaligned_err <= 1'b0;
            strobe_err     <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        if (w_multi) begin
                            strobe_err <= 1'b1;
                            done       <= 1'b1;
                            r_state    <= DONE;
                        end else if (w_cross && !SPLIT_MISALIGNED) begin
                            misaligned_err <= 1'b1;
                            done           <= 1'b1;
                            r_state        <= DONE;
                        end else begin
                            r_off     <= addr[1:0];
                            r_size    <= w_size;
                            r_sign    <= w_sign;
                            r_we      <= w_we;
                            r_split   <= w_cross;
                            r_addr0   <= w_addr_word;
                            r_st_hi   <= w_st_data[63:32];
                            r_be_hi   <= w_be[7:4];
                            mem_req   <= 1'b1;
                            mem_we    <= w_we;
                            mem_addr  <= w_addr_word;
                            mem_be    <= w_be[3:0];
                            mem_wdata <= w_st_data[31:0];
                            r_state   <= REQ0;
                        end
                    end
                end
                REQ0, REQ1: begin
                    if (mem_gnt) begin
                        if (r_we && r_state == REQ0 && r_split) begin
                            mem_addr  <= r_addr0 + ADDR_W'(4);
                            mem_be    <= r_be_hi;
                            mem_wdata <= r_st_hi;
                            r_state   <= REQ1;
                        end else begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            mem_be  <= '0;
                            if (!r_we) begin
                                r_state <= (r_state == REQ0) ? WAIT0 : WAIT1;
                            end else begin
                                done    <= 1'b1;
                                r_state <= DONE;
                            end
                        end
                    end
                end
                WAIT0: begin
                    if (mem_rvalid) begin
                        r_word0 <= mem_rdata;
                        if (r_split) begin
                            mem_req  <= 1'b1;
                            mem_addr <= r_addr0 + ADDR_W'(4);
                            mem_be   <= r_be_hi;
                            r_state  <= REQ1;
                        end else begin
                            rdata   <= w_ld_data;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        rdata   <= w_ld_data;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done           <= 1'b0;
                    strobe_err     <= 1'b0;
                    misaligned_err <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: vector table of accesses plus reset/error sequences.
// Latency: n/a.
// Backpressure: bench memory withholds gnt per vector and returns rvalid one cycle after gnt.
module tb_lsu_mem_access;

    localparam logic [7:0] LB  = 8'h80;
    localparam logic [7:0] LH  = 8'h40;
    localparam logic [7:0] LW  = 8'h20;
    localparam logic [7:0] ULB = 8'h10;
    localparam logic [7:0] ULH = 8'h08;
    localparam logic [7:0] SB  = 8'h04;
    localparam logic [7:0] SH  = 8'h02;
    localparam logic [7:0] SW  = 8'h01;
    localparam logic [7:0] ST_MASK = 8'h07;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  strb, strb1;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_gnt, mem_rvalid;
    logic        gnt1, rvalid1;

    logic        stall, done, misaligned_err, strobe_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        stall1, done1, misaligned_err1, strobe_err1, mem_req1, mem_we1;
    logic [31:0] rdata1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_be1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_access #(.SPLIT_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ldr_byte(strb[7]), .ldr_half(strb[6]), .ldr_word(strb[5]),
        .uldr_byte(strb[4]), .uldr_half(strb[3]),
        .str_byte(strb[2]), .str_half(strb[1]), .str_word(strb[0]),
        .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .done(done),
        .misaligned_err(misaligned_err), .strobe_err(strobe_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_access #(.SPLIT_MISALIGNED(1'b0), .ADDR_W(32)) dut_nosplit (
        .clk(clk), .rst_n(rst_n),
        .ldr_byte(strb1[7]), .ldr_half(strb1[6]), .ldr_word(strb1[5]),
        .uldr_byte(strb1[4]), .uldr_half(strb1[3]),
        .str_byte(strb1[2]), .str_half(strb1[1]), .str_word(strb1[0]),
        .addr(addr), .wdata(wdata),
        .stall(stall1), .rdata(rdata1), .done(done1),
        .misaligned_err(misaligned_err1), .strobe_err(strobe_err1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_be(mem_be1), .mem_wdata(mem_wdata1),
        .mem_gnt(gnt1), .mem_rvalid(rvalid1), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [7:0]  s;
        logic [31:0] a, wd, w0, w1;
        int          gdly;
        int          nreq;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rd;
        int          cyc;
    } vec_t;

    int          got_n, got_cyc, stall_bad, unstable;
    logic [31:0] got_a [2];
    logic [3:0]  got_be [2];
    logic        got_we [2];
    logic [31:0] got_wd [2];
    logic [31:0] got_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] s, input logic [31:0] a, wd, w0, w1, input int gdly,
                                input int nreq, input logic [31:0] a0, input logic [3:0] be0,
                                input logic [31:0] wd0, input logic [31:0] a1, input logic [3:0] be1,
                                input logic [31:0] wd1, input logic [31:0] rd, input int cyc);
        vec_t v;
        v.s = s; v.a = a; v.wd = wd; v.w0 = w0; v.w1 = w1; v.gdly = gdly;
        v.nreq = nreq; v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
        v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.rd = rd; v.cyc = cyc;
        return v;
    endfunction

    // Plays the memory: gnt after gdly held cycles, rvalid one cycle after a read gnt.
    task automatic run_access(input logic [7:0] s, input logic [31:0] a, wd, w0, w1, input int gdly);
        int          held = 0;
        bit          rv_pend = 1'b0;
        logic [31:0] rv_dat = '0;
        logic [31:0] ha = '0;
        logic [3:0]  hbe = '0;
        got_n = 0; got_cyc = -1; stall_bad = 0; unstable = 0; got_rd = '0;
        @(negedge clk);
        strb = s; addr = a; wdata = wd;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            mem_rvalid = rv_pend;
            mem_rdata  = rv_dat;
            rv_pend    = 1'b0;
            mem_gnt    = 1'b0;
            if (done) begin
                got_cyc = k;
                got_rd  = rdata;
                strb    = '0;
                break;
            end
            if (!stall) stall_bad++;
            if (mem_req) begin
                if (held == 0) begin
                    ha = mem_addr; hbe = mem_be;
                end else if (mem_addr !== ha || mem_be !== hbe) begin
                    unstable++;
                end
                if (held < gdly) begin
                    held++;
                end else begin
                    if (got_n < 2) begin
                        got_a[got_n] = mem_addr; got_be[got_n] = mem_be;
                        got_we[got_n] = mem_we; got_wd[got_n] = mem_wdata;
                    end
                    got_n++;
                    mem_gnt = 1'b1;
                    held = 0;
                    if (!mem_we) begin
                        rv_pend = 1'b1;
                        rv_dat  = (got_n == 1) ? w0 : w1;
                    end
                end
            end
        end
        strb = '0;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    vec_t vt [14];

    initial begin
        int n_se, n_rq, n_dn, n_me;
        logic is_st;

        vt[0]  = mk(SW,  32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 2);
        vt[1]  = mk(LB,  32'h203, 0, 32'h80112233, 0, 0, 1, 32'h200, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80, 3);
        vt[2]  = mk(ULB, 32'h203, 0, 32'h80112233, 0, 0, 1, 32'h200, 4'h8, 0, 0, 0, 0, 32'h00000080, 3);
        vt[3]  = mk(LW,  32'h0FE, 0, 32'hAABBCCDD, 32'h11223344, 0, 2, 32'h0FC, 4'hC, 0,
                    32'h100, 4'h3, 0, 32'h3344AABB, 5);
        vt[4]  = mk(SH,  32'h107, 32'h0000BEEF, 0, 0, 0, 2, 32'h104, 4'h8, 32'hEF000000,
                    32'h108, 4'h1, 32'h000000BE, 0, 3);
        vt[5]  = mk(LH,  32'h301, 0, 32'h11800122, 0, 0, 1, 32'h300, 4'h6, 0, 0, 0, 0, 32'hFFFF8001, 3);
        vt[6]  = mk(ULH, 32'h302, 0, 32'h9ABC1234, 0, 0, 1, 32'h300, 4'hC, 0, 0, 0, 0, 32'h00009ABC, 3);
        vt[7]  = mk(SB,  32'h401, 32'h000000A5, 0, 0, 0, 1, 32'h400, 4'h2, 32'h0000A500, 0, 0, 0, 0, 2);
        vt[8]  = mk(LH,  32'h3FF, 0, 32'h7F000000, 32'h000000FE, 0, 2, 32'h3FC, 4'h8, 0,
                    32'h400, 4'h1, 0, 32'hFFFFFE7F, 5);
        vt[9]  = mk(SW,  32'h006, 32'h11223344, 0, 0, 0, 2, 32'h004, 4'hC, 32'h33440000,
                    32'h008, 4'h3, 32'h00001122, 0, 3);
        vt[10] = mk(LW,  32'hFFFFFFFD, 0, 32'h44332211, 32'h88776655, 0, 2, 32'hFFFFFFFC, 4'hE, 0,
                    32'h00000000, 4'h1, 0, 32'h55443322, 5);
        vt[11] = mk(SH,  32'hA02, 32'h0000CAFE, 0, 0, 0, 1, 32'hA00, 4'hC, 32'hCAFE0000, 0, 0, 0, 0, 2);
        vt[12] = mk(SW,  32'h500, 32'h01020304, 0, 0, 4, 1, 32'h500, 4'hF, 32'h01020304, 0, 0, 0, 0, 6);
        vt[13] = mk(LW,  32'h800, 0, 32'hCAFEF00D, 0, 2, 1, 32'h800, 4'hF, 0, 0, 0, 0, 32'hCAFEF00D, 5);

        rst_n = 1'b0; strb = '0; strb1 = '0; addr = '0; wdata = '0; mem_rdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; gnt1 = 1'b1; rvalid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mem_req", {31'b0, mem_req}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_be_we", {27'b0, mem_we, mem_be}, 0);
        chk("reset_flags", {28'b0, done, misaligned_err, strobe_err, stall}, 0);
        chk("reset_rdata_wdata", rdata | mem_wdata, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            is_st = |(vt[i].s & ST_MASK);
            run_access(vt[i].s, vt[i].a, vt[i].wd, vt[i].w0, vt[i].w1, vt[i].gdly);
            chk($sformatf("v%0d_done_cycle", i), got_cyc, vt[i].cyc);
            chk($sformatf("v%0d_nreq", i), got_n, vt[i].nreq);
            chk($sformatf("v%0d_stall", i), stall_bad, 0);
            chk($sformatf("v%0d_req_stable", i), unstable, 0);
            chk($sformatf("v%0d_addr0", i), got_a[0], vt[i].a0);
            chk($sformatf("v%0d_be0_we0", i), {27'b0, got_we[0], got_be[0]}, {27'b0, is_st, vt[i].be0});
            if (is_st) chk($sformatf("v%0d_wdata0", i), got_wd[0], vt[i].wd0);
            else       chk($sformatf("v%0d_rdata", i), got_rd, vt[i].rd);
            if (vt[i].nreq == 2) begin
                chk($sformatf("v%0d_addr1", i), got_a[1], vt[i].a1);
                chk($sformatf("v%0d_be1_we1", i), {27'b0, got_we[1], got_be[1]}, {27'b0, is_st, vt[i].be1});
                if (is_st) chk($sformatf("v%0d_wdata1", i), got_wd[1], vt[i].wd1);
            end
        end

        // Two strobes at once: single error pulse, no memory traffic.
        @(negedge clk);
        strb = LW | SW; addr = 32'h100;
        #1 chk("multi_strobe_stall", {31'b0, stall}, 1);
        n_se = 0; n_rq = 0; n_dn = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("strobe_err_pulse", {31'b0, strobe_err}, 1);
                chk("strobe_err_done", {31'b0, done}, 1);
                strb = '0;
            end
            n_se += int'(strobe_err); n_rq += int'(mem_req); n_dn += int'(done);
        end
        chk("strobe_err_cycles", n_se, 1);
        chk("strobe_err_no_req", n_rq, 0);
        chk("strobe_err_done_cycles", n_dn, 1);

        // Non-splitting instance: misaligned word flagged, no request.
        @(negedge clk);
        strb1 = LW; addr = 32'h101;
        n_me = 0; n_rq = 0; n_dn = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("misaligned_err_pulse", {31'b0, misaligned_err1}, 1);
                strb1 = '0;
            end
            n_me += int'(misaligned_err1); n_rq += int'(mem_req1); n_dn += int'(done1);
        end
        chk("misaligned_err_cycles", n_me, 1);
        chk("misaligned_no_req", n_rq, 0);
        chk("misaligned_done_cycles", n_dn, 1);
        chk("nosplit_no_traffic", mem_addr1 | mem_wdata1 | rdata1 | {27'b0, mem_we1, mem_be1}, 0);
        chk("nosplit_idle_flags", {29'b0, stall1, strobe_err1, misaligned_err1}, 0);

        // Reset while waiting for read data, then a stray rvalid.
        @(negedge clk);
        strb = LW; addr = 32'h600;
        @(negedge clk);
        chk("rst_seq_req", {31'b0, mem_req}, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait0_stall", {31'b0, stall}, 1);
        strb = '0; rst_n = 1'b0;
        #1;
        chk("rst_abort_req", {31'b0, mem_req}, 0);
        chk("rst_abort_addr", mem_addr, 0);
        chk("rst_abort_idle", {31'b0, stall}, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        n_dn = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            n_dn += int'(done);
        end
        chk("stray_rvalid_no_done", n_dn, 0);

        run_access(SW, 32'h700, 32'h55AA55AA, 0, 0, 0);
        chk("post_reset_done_cycle", got_cyc, 2);
        chk("post_reset_wdata", got_wd[0], 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
